// File: rtl/count_initiator.sv
`default_nettype none
// ============================================================================
// Module      : count_initiator
// Description : Runs a programmable number of handshake rounds against a
//               down-counter responder. Each round arms the responder with a
//               one-cycle initSignal pulse, waits for finalSignal to rise,
//               releases it with a second pulse and waits for finalSignal to
//               fall. Each wait is bounded by TIMEOUT cycles; overrunning
//               either wait raises a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module count_initiator #(
    parameter int TIMEOUT = 31
) (
    input  logic       clk_out,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] rounds,
    input  logic       finalSignal,
    output logic       initSignal,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] roundCount,
    output logic [4:0] waitCycles
);

    // Wait budget narrowed to the waitCycles width; legal range is 1..31.
    localparam logic [4:0] c_TIMEOUT = 5'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARM        = 3'd1,
        S_WAIT_FINAL = 3'd2,
        S_RELEASE    = 3'd3,
        S_WAIT_CLEAR = 3'd4,
        S_DONE       = 3'd5,
        S_ERROR      = 3'd6
    } state_t;

    state_t     r_state;
    logic [3:0] r_rounds;      // round target latched when start is accepted
    logic [3:0] w_next_count;  // round count after the round now finishing

    // Round count as it will be once the current WAIT_CLEAR round completes.
    assign w_next_count = roundCount + 4'd1;

    // Sequencer: every output is produced from the transition into the state
    // it belongs to, so initSignal is high exactly while in ARM or RELEASE
    // and done is high exactly while in DONE.
    always_ff @(posedge clk_out) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rounds   <= 4'd0;
            initSignal <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            roundCount <= 4'd0;
            waitCycles <= 5'd0;
        end else begin
            initSignal <= 1'b0;
            done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        roundCount <= 4'd0;
                        error      <= 1'b0;
                        if (rounds != 4'd0) begin
                            r_rounds   <= rounds;
                            busy       <= 1'b1;
                            initSignal <= 1'b1;
                            r_state    <= S_ARM;
                        end else begin
                            // Nothing to run: report completion straight away.
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end

                S_ARM: begin
                    waitCycles <= 5'd0;
                    r_state    <= S_WAIT_FINAL;
                end

                S_WAIT_FINAL: begin
                    if (finalSignal) begin
                        initSignal <= 1'b1;
                        r_state    <= S_RELEASE;
                    end else if (waitCycles >= c_TIMEOUT) begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_ERROR;
                    end else begin
                        // Only counts below TIMEOUT, so it saturates there.
                        waitCycles <= waitCycles + 5'd1;
                    end
                end

                S_RELEASE: begin
                    waitCycles <= 5'd0;
                    r_state    <= S_WAIT_CLEAR;
                end

                S_WAIT_CLEAR: begin
                    if (!finalSignal) begin
                        roundCount <= w_next_count;
                        if (w_next_count == r_rounds) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            initSignal <= 1'b1;
                            r_state    <= S_ARM;
                        end
                    end else if (waitCycles >= c_TIMEOUT) begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_ERROR;
                    end else begin
                        waitCycles <= waitCycles + 5'd1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                S_ERROR: begin
                    error   <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    // Unused encoding: recover to a quiet idle.
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_initiator
// Description : Directed bench for count_initiator with a down-counter
//               responder model (raises finalSignal 17 cycles after an arming
//               pulse, drops it 1 cycle after a release pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_initiator;

    logic       clk_out = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] rounds;
    logic       finalSignal;
    logic       initSignal;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] roundCount;
    logic [4:0] waitCycles;

    int checks = 0;
    int fails  = 0;

    // Responder model state
    logic resp_en    = 1'b0;
    logic resp_final = 1'b0;
    logic final_force = 1'b0;
    logic drop_pend  = 1'b0;
    int   resp_cnt   = 0;

    // Pulse monitors
    int   init_pulses = 0;
    int   done_pulses = 0;
    int   init_long   = 0;
    logic prev_init   = 1'b0;

    assign finalSignal = resp_en ? resp_final : final_force;

    always #5 clk_out = ~clk_out;

    count_initiator #(.TIMEOUT(31)) dut (
        .clk_out     (clk_out),
        .reset       (reset),
        .start       (start),
        .rounds      (rounds),
        .finalSignal (finalSignal),
        .initSignal  (initSignal),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .roundCount  (roundCount),
        .waitCycles  (waitCycles)
    );

    // Responder: reacts to initSignal seen mid-cycle.
    always @(negedge clk_out) begin
        if (reset || !resp_en) begin
            resp_final = 1'b0;
            resp_cnt   = 0;
            drop_pend  = 1'b0;
        end else begin
            if (drop_pend) begin
                resp_final = 1'b0;
                drop_pend  = 1'b0;
            end
            if (resp_cnt > 0) begin
                resp_cnt = resp_cnt - 1;
                if (resp_cnt == 0) resp_final = 1'b1;
            end
            if (initSignal) begin
                if (resp_final) drop_pend = 1'b1;
                else            resp_cnt  = 17;
            end
        end
    end

    // Count pulses and catch any initSignal wider than one cycle.
    always @(negedge clk_out) begin
        if (initSignal) init_pulses = init_pulses + 1;
        if (initSignal && prev_init) init_long = init_long + 1;
        if (done) done_pulses = done_pulses + 1;
        prev_init = initSignal;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_out);
    endtask

    // Present start for exactly one rising edge; returns mid-cycle after it.
    task automatic do_start(input logic [3:0] r);
        start  = 1'b1;
        rounds = r;
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) until done is observed high.
    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    int base_init;
    int base_done;
    int n;

    initial begin
        // ---- Reset with arbitrary inputs ----
        reset       = 1'b1;
        start       = 1'b1;
        rounds      = 4'd7;
        final_force = 1'b1;
        tick();
        tick();
        check("rst_init",   {31'd0, initSignal}, 32'd0);
        check("rst_busy",   {31'd0, busy},       32'd0);
        check("rst_done",   {31'd0, done},       32'd0);
        check("rst_error",  {31'd0, error},      32'd0);
        check("rst_rcount", {28'd0, roundCount}, 32'd0);
        check("rst_wait",   {27'd0, waitCycles}, 32'd0);
        check("rst_pulses", init_pulses,         32'd0);
        start       = 1'b0;
        rounds      = 4'd0;
        final_force = 1'b0;
        reset       = 1'b0;
        tick();

        // ---- Two rounds against the responder ----
        resp_en   = 1'b1;
        base_init = init_pulses;
        base_done = done_pulses;
        do_start(4'd2);
        check("r2_first_init", {31'd0, initSignal}, 32'd1);
        check("r2_busy",       {31'd0, busy},       32'd1);
        tick();
        check("r2_init_1cyc",  {31'd0, initSignal}, 32'd0);
        wait_done("r2_done_seen", 80);
        check("r2_rcount",     {28'd0, roundCount}, 32'd2);
        check("r2_busy_done",  {31'd0, busy},       32'd0);
        tick();
        check("r2_done_1cyc",  {31'd0, done},       32'd0);
        check("r2_error",      {31'd0, error},      32'd0);
        check("r2_pulses",     init_pulses - base_init, 32'd4);
        check("r2_done_cnt",   done_pulses - base_done, 32'd1);
        check("r2_pulse_wide", init_long, 32'd0);

        // ---- Zero rounds ----
        base_init = init_pulses;
        do_start(4'd0);
        check("r0_done",   {31'd0, done},       32'd1);
        check("r0_rcount", {28'd0, roundCount}, 32'd0);
        check("r0_busy",   {31'd0, busy},       32'd0);
        tick();
        check("r0_done_1cyc", {31'd0, done}, 32'd0);
        check("r0_pulses", init_pulses - base_init, 32'd0);

        // ---- Timeout in WAIT_FINAL ----
        resp_en   = 1'b0;
        base_init = init_pulses;
        do_start(4'd1);
        n = 0;
        while (error !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("to_error_seen", {31'd0, error}, 32'd1);
        // ARM, then waitCycles 0..31, then the timeout edge.
        check("to_latency",    n, 32'd33);
        check("to_wait_sat",   {27'd0, waitCycles}, 32'd31);
        check("to_busy",       {31'd0, busy},       32'd0);
        tick();
        tick();
        tick();
        check("to_sticky",     {31'd0, error}, 32'd1);
        check("to_pulses",     init_pulses - base_init, 32'd1);
        do_start(4'd0);
        check("to_err_clear",  {31'd0, error}, 32'd0);
        check("to_clear_done", {31'd0, done},  32'd1);
        tick();

        // ---- start/rounds changes while busy are ignored ----
        resp_en   = 1'b1;
        base_init = init_pulses;
        do_start(4'd1);
        tick();
        tick();
        start  = 1'b1;
        rounds = 4'd5;
        tick();
        start = 1'b0;
        wait_done("ign_done_seen", 80);
        check("ign_rcount", {28'd0, roundCount}, 32'd1);
        tick();
        check("ign_pulses", init_pulses - base_init, 32'd2);
        check("ign_busy",   {31'd0, busy}, 32'd0);

        // ---- Reset in WAIT_FINAL with waitCycles=10 ----
        do_start(4'd3);
        n = 0;
        while (waitCycles !== 5'd10 && n < 40) begin
            tick();
            n++;
        end
        check("mr_wait10", {27'd0, waitCycles}, 32'd10);
        check("mr_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        check("mr_init",   {31'd0, initSignal}, 32'd0);
        check("mr_busy",   {31'd0, busy},       32'd0);
        check("mr_done",   {31'd0, done},       32'd0);
        check("mr_error",  {31'd0, error},      32'd0);
        check("mr_rcount", {28'd0, roundCount}, 32'd0);
        check("mr_wait",   {27'd0, waitCycles}, 32'd0);
        reset = 1'b0;
        tick();
        base_init = init_pulses;
        do_start(4'd1);
        check("mr2_init", {31'd0, initSignal}, 32'd1);
        wait_done("mr2_done_seen", 80);
        check("mr2_rcount", {28'd0, roundCount}, 32'd1);
        check("mr2_pulses", init_pulses - base_init, 32'd2);
        check("all_pulse_wide", init_long, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
